// File: rtl/systolic_pe_mac_if.sv
`default_nettype none
// ============================================================================
// Module   : systolic_pe_mac_if
// Brief    : Operand-beat / result handshake bundle between the delay stage,
//            the systolic PE MAC and the result collector.
// Revision : 1.0
// ============================================================================
interface systolic_pe_mac_if #(
    parameter int REG_WIDTH = 16,
    parameter int VECTOR    = 1,
    parameter int ACC_WIDTH = 2*REG_WIDTH+8,
    parameter int K_W       = 16
);
    logic                        start;
    logic [K_W-1:0]              k_len;
    logic                        in_valid;
    logic signed [REG_WIDTH-1:0] a_n [VECTOR];
    logic signed [REG_WIDTH-1:0] b_n [VECTOR];
    logic signed [ACC_WIDTH-1:0] acc_out;
    logic                        out_valid;
    logic                        out_ready;
    logic                        busy;

    modport master (
        output start, k_len, in_valid, a_n, b_n, out_ready,
        input  acc_out, out_valid, busy
    );

    modport slave (
        input  start, k_len, in_valid, a_n, b_n, out_ready,
        output acc_out, out_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/systolic_pe_mac.sv
`default_nettype none
// ============================================================================
// Module   : systolic_pe_mac
// Brief    : Systolic-array PE: signed VECTOR-lane MAC over a K-beat dot
//            product, result held on valid/ready until drained.
//            Optional macro PE_ACC_SATURATE_EN: saturating, sticky accumulate.
// Revision : 1.0
// ============================================================================
module systolic_pe_mac #(
    parameter int REG_WIDTH = 16,
    parameter int VECTOR    = 1,
    parameter int ACC_WIDTH = 2*REG_WIDTH+8,
    parameter int K_W       = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    systolic_pe_mac_if.slave   bus
);

    localparam int PROD_W = 2*REG_WIDTH;
`ifdef PE_ACC_SATURATE_EN
    // Guard bits so the lane sum plus accumulator can never wrap before clamping.
    localparam int SUM_W  = ACC_WIDTH + $clog2(VECTOR) + 2;
`else
    localparam int SUM_W  = ACC_WIDTH;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                      r_state;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic [K_W-1:0]              r_count;
    logic [K_W-1:0]              r_k_len;
    logic                        r_out_valid;
    logic                        r_busy;

    logic signed [PROD_W-1:0]    w_a_ext  [VECTOR];
    logic signed [PROD_W-1:0]    w_b_ext  [VECTOR];
    logic signed [PROD_W-1:0]    w_prod   [VECTOR];
    logic signed [SUM_W-1:0]     w_beat_sum;
    logic signed [ACC_WIDTH-1:0] w_acc_next;
    logic                        w_start_accept;
    logic                        w_beat_fire;
    logic                        w_last_beat;

    generate
        for (genvar gi = 0; gi < VECTOR; gi++) begin : g_lane
            assign w_a_ext[gi] = {{REG_WIDTH{bus.a_n[gi][REG_WIDTH-1]}}, bus.a_n[gi]};
            assign w_b_ext[gi] = {{REG_WIDTH{bus.b_n[gi][REG_WIDTH-1]}}, bus.b_n[gi]};
            assign w_prod[gi]  = w_a_ext[gi] * w_b_ext[gi];
        end
    endgenerate

    always_comb begin
        w_beat_sum = '0;
        for (int i = 0; i < VECTOR; i++) begin
            w_beat_sum = w_beat_sum + {{(SUM_W-PROD_W){w_prod[i][PROD_W-1]}}, w_prod[i]};
        end
    end

`ifdef PE_ACC_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] c_ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] c_ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [SUM_W-1:0]     c_SUM_MAX =
        {{(SUM_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0]     c_SUM_MIN =
        {{(SUM_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

    logic signed [SUM_W-1:0] w_sum_ext;
    logic                    w_ovf_pos;
    logic                    w_ovf_neg;
    logic                    r_sticky;

    assign w_sum_ext  = {{(SUM_W-ACC_WIDTH){r_acc[ACC_WIDTH-1]}}, r_acc} + w_beat_sum;
    assign w_ovf_pos  = (w_sum_ext > c_SUM_MAX);
    assign w_ovf_neg  = (w_sum_ext < c_SUM_MIN);
    // Once clamped, the accumulator freezes at the rail until the next start.
    assign w_acc_next = r_sticky  ? r_acc     :
                        w_ovf_pos ? c_ACC_MAX :
                        w_ovf_neg ? c_ACC_MIN :
                                    w_sum_ext[ACC_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
        end else if (w_start_accept) begin
            r_sticky <= 1'b0;
        end else if (w_beat_fire && (w_ovf_pos || w_ovf_neg)) begin
            r_sticky <= 1'b1;
        end
    end
`else
    assign w_acc_next = r_acc + w_beat_sum;
`endif

    assign w_start_accept = bus.start &&
                            ((r_state == S_IDLE) || ((r_state == S_DRAIN) && bus.out_ready));
    assign w_beat_fire    = (r_state == S_ACCUM) && bus.in_valid;
    assign w_last_beat    = (r_count == (r_k_len - K_W'(1)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_k_len     <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_start_accept) begin
            // Covers both a fresh start from IDLE and a back-to-back start on drain.
            r_acc   <= '0;
            r_count <= '0;
            r_k_len <= bus.k_len;
            r_busy  <= 1'b1;
            if (bus.k_len == '0) begin
                r_state     <= S_DRAIN;
                r_out_valid <= 1'b1;
            end else begin
                r_state     <= S_ACCUM;
                r_out_valid <= 1'b0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
                S_ACCUM: begin
                    if (bus.in_valid) begin
                        r_acc   <= w_acc_next;
                        r_count <= r_count + K_W'(1);
                        if (w_last_beat) begin
                            r_state     <= S_DRAIN;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.acc_out   = r_acc;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_systolic_pe_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_pe_mac
// Brief    : Self-checking bench: directed vector table, hand-written corner
//            sequences and randomized jobs against a plain-arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_systolic_pe_mac;

    localparam int RW = 16;
    localparam int VW = 2;
    localparam int AW = 32;
    localparam int KW = 16;
    localparam longint c_MAX = 64'sd2147483647;
    localparam longint c_MIN = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst_n;

    systolic_pe_mac_if #(.REG_WIDTH(RW), .VECTOR(VW), .ACC_WIDTH(AW), .K_W(KW)) bus ();

    systolic_pe_mac #(.REG_WIDTH(RW), .VECTOR(VW), .ACC_WIDTH(AW), .K_W(KW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a0;
        logic [15:0] a1;
        logic [15:0] b0;
        logic [15:0] b1;
    } beat_t;

    typedef struct packed {
        int          k;
        beat_t [3:0] beats;
        logic [31:0] exp;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    int   ba [64][2];
    int   bb [64][2];
    vec_t vecs [6];

    function automatic beat_t mk(input int a0, input int a1, input int b0, input int b1);
        beat_t r;
        r.a0 = 16'(a0); r.a1 = 16'(a1); r.b0 = 16'(b0); r.b1 = 16'(b1);
        return r;
    endfunction

    // Dot product from the arithmetic rules, one clamp/wrap decision per beat.
    function automatic longint model(input int k);
        longint acc = 0;
        longint s;
        bit     stick = 1'b0;
        for (int i = 0; i < k; i++) begin
            s = longint'(ba[i][0]) * longint'(bb[i][0]) + longint'(ba[i][1]) * longint'(bb[i][1]);
`ifdef PE_ACC_SATURATE_EN
            if (!stick) begin
                acc = acc + s;
                if (acc > c_MAX) begin acc = c_MAX; stick = 1'b1; end
                else if (acc < c_MIN) begin acc = c_MIN; stick = 1'b1; end
            end
`else
            acc = acc + s;
            acc = longint'($signed(acc[31:0]));
`endif
        end
        return acc;
    endfunction

    function automatic int rnd_op();
        case ($urandom_range(0, 3))
            0:       return 32767;
            1:       return -32768;
            default: return int'($signed(16'($urandom)));
        endcase
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive_garbage();
        for (int l = 0; l < VW; l++) begin
            bus.a_n[l] = 16'($urandom);
            bus.b_n[l] = 16'($urandom);
        end
    endtask

    task automatic do_start(input int k, input string nm);
        bus.start = 1'b1;
        bus.k_len = 16'(k);
        cycle();
        bus.start = 1'b0;
        if (k != 0) begin
            check({nm, ".busy_after_start"}, longint'(bus.busy), 1);
            check({nm, ".valid_after_start"}, longint'(bus.out_valid), 0);
        end
    endtask

    // stall: 0 none, 1 every other cycle, 2 random
    task automatic feed(input int k, input int stall);
        for (int i = 0; i < k; i++) begin
            if (stall == 1 || (stall == 2 && $urandom_range(0, 1) == 1)) begin
                bus.in_valid = 1'b0;
                drive_garbage();
                cycle();
            end
            bus.in_valid = 1'b1;
            bus.a_n[0] = 16'(ba[i][0]); bus.a_n[1] = 16'(ba[i][1]);
            bus.b_n[0] = 16'(bb[i][0]); bus.b_n[1] = 16'(bb[i][1]);
            cycle();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_result(input string nm, input longint exp, input int hold);
        check({nm, ".valid"}, longint'(bus.out_valid), 1);
        check({nm, ".acc"}, longint'(bus.acc_out), exp);
        for (int h = 0; h < hold; h++) begin
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b1;
            drive_garbage();
            cycle();
            check({nm, ".hold_valid"}, longint'(bus.out_valid), 1);
            check({nm, ".hold_acc"}, longint'(bus.acc_out), exp);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        check({nm, ".drained_valid"}, longint'(bus.out_valid), 0);
        check({nm, ".drained_busy"}, longint'(bus.busy), 0);
    endtask

    task automatic load_vec(input int v);
        for (int i = 0; i < 4; i++) begin
            ba[i][0] = int'($signed(vecs[v].beats[i].a0));
            ba[i][1] = int'($signed(vecs[v].beats[i].a1));
            bb[i][0] = int'($signed(vecs[v].beats[i].b0));
            bb[i][1] = int'($signed(vecs[v].beats[i].b1));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{k: 3, beats: {mk(0,0,0,0), mk(5,6,-1,-1), mk(3,4,2,2), mk(1,2,1,1)}, exp: 32'(6)};
        vecs[1] = '{k: 1, beats: {mk(0,0,0,0), mk(0,0,0,0), mk(0,0,0,0), mk(2,2,3,3)}, exp: 32'(12)};
        vecs[2] = '{k: 2, beats: {mk(0,0,0,0), mk(0,0,0,0), mk(100,-100,10,10), mk(-5,7,3,2)}, exp: 32'(-1)};
        vecs[3] = '{k: 4, beats: {mk(1,1,-32768,-32768), mk(1,1,-32768,-32768),
                                  mk(1,1,-32768,-32768), mk(1,1,-32768,-32768)}, exp: 32'(-262144)};
`ifdef PE_ACC_SATURATE_EN
        vecs[4] = '{k: 2, beats: {mk(0,0,0,0), mk(0,0,0,0), mk(32767,32767,32767,32767),
                                  mk(32767,32767,32767,32767)}, exp: 32'(2147483647)};
        vecs[5] = '{k: 2, beats: {mk(0,0,0,0), mk(0,0,0,0), mk(-32768,-32768,-32768,-32768),
                                  mk(-32768,-32768,-32768,-32768)}, exp: 32'(2147483647)};
`else
        vecs[4] = '{k: 2, beats: {mk(0,0,0,0), mk(0,0,0,0), mk(32767,32767,32767,32767),
                                  mk(32767,32767,32767,32767)}, exp: 32'(-262140)};
        vecs[5] = '{k: 2, beats: {mk(0,0,0,0), mk(0,0,0,0), mk(-32768,-32768,-32768,-32768),
                                  mk(-32768,-32768,-32768,-32768)}, exp: 32'(0)};
`endif

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.k_len     = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive_garbage();
        cycle();
        cycle();
        check("reset.valid", longint'(bus.out_valid), 0);
        check("reset.busy", longint'(bus.busy), 0);
        check("reset.acc", longint'(bus.acc_out), 0);
        rst_n = 1'b1;

        // in_valid must be ignored while idle
        bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        check("idle.ignore_acc", longint'(bus.acc_out), 0);

        for (int v = 0; v < 6; v++) begin
            load_vec(v);
            do_start(vecs[v].k, $sformatf("vec%0d", v));
            feed(vecs[v].k, 0);
            expect_result($sformatf("vec%0d", v), longint'($signed(vecs[v].exp)), 1);
        end

        // Alternate-cycle stalls plus 5 cycles of backpressure
        load_vec(0);
        do_start(3, "stall");
        feed(3, 1);
        expect_result("stall", 6, 5);

        // Back-to-back: new start on the drain handshake, no idle bubble
        load_vec(0);
        do_start(3, "b2b_first");
        feed(3, 0);
        check("b2b_first.acc", longint'(bus.acc_out), 6);
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        bus.k_len     = 16'd1;
        bus.in_valid  = 1'b1;
        bus.a_n[0] = 16'sd7; bus.a_n[1] = 16'sd7;
        bus.b_n[0] = 16'sd7; bus.b_n[1] = 16'sd7;
        cycle();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        check("b2b.no_bubble_busy", longint'(bus.busy), 1);
        check("b2b.no_bubble_valid", longint'(bus.out_valid), 0);
        check("b2b.cleared_acc", longint'(bus.acc_out), 0);
        ba[0][0] = 2; ba[0][1] = 2; bb[0][0] = 3; bb[0][1] = 3;
        feed(1, 0);
        expect_result("b2b", 12, 0);

        // Zero-length dot product
        do_start(0, "klen0");
        expect_result("klen0", 0, 2);

        // Reset in the middle of an accumulation
        for (int i = 0; i < 5; i++) begin
            ba[i][0] = 1000; ba[i][1] = 1000; bb[i][0] = 3; bb[i][1] = 3;
        end
        do_start(5, "midrst");
        feed(2, 0);
        rst_n = 1'b0;
        cycle();
        cycle();
        check("midrst.valid", longint'(bus.out_valid), 0);
        check("midrst.busy", longint'(bus.busy), 0);
        check("midrst.acc", longint'(bus.acc_out), 0);
        rst_n = 1'b1;
        load_vec(1);
        do_start(1, "after_rst");
        feed(1, 0);
        expect_result("after_rst", 12, 0);

        // Randomized jobs against the reference model
        for (int t = 0; t < 40; t++) begin
            int k;
            k = $urandom_range(0, 8);
            for (int i = 0; i < k; i++) begin
                ba[i][0] = rnd_op(); ba[i][1] = rnd_op();
                bb[i][0] = rnd_op(); bb[i][1] = rnd_op();
            end
            do_start(k, $sformatf("rnd%0d", t));
            feed(k, 2);
            expect_result($sformatf("rnd%0d", t), model(k), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
